// File: rtl/mul8_seq_ctrl.sv
// Sequencing controller: time-shares one external 4x4 multiplier between two
// requesters, building each 8x8 product from four shifted nibble products.
module mul8_seq_ctrl #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        req1_ready,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_p,
  output logic        res_id,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        id_q, id_d;
  logic [15:0] acc_q, acc_d;
  logic [1:0]  pass_q, pass_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic        last_id_q, last_id_d;
  logic        busy_q, busy_d;

  logic        idle;
  logic        grant_any;
  logic        grant_id;
  logic        pass_end;
  logic [15:0] pp_shifted;

  // Round-robin only matters on a tie; a lone requester always wins.
  always_comb begin
    idle      = (state_q == ST_IDLE);
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_id_q;
    end else begin
      grant_id = req1_valid;
    end
    req0_ready = idle & grant_any & ~grant_id;
    req1_ready = idle & grant_any & grant_id;
  end

  // Pass index bit 0 selects the multiplicand nibble, bit 1 the multiplier nibble.
  always_comb begin
    mul_a = 4'h0;
    mul_b = 4'h0;
    if (state_q == ST_PASS) begin
      mul_a = pass_q[0] ? a_q[7:4] : a_q[3:0];
      mul_b = pass_q[1] ? b_q[7:4] : b_q[3:0];
    end
  end

  always_comb begin
    case (pass_q)
      2'd0:    pp_shifted = {8'h00, mul_p};
      2'd3:    pp_shifted = {mul_p, 8'h00};
      default: pp_shifted = {4'h0, mul_p, 4'h0};
    endcase
  end

  assign pass_end = (wcnt_q == WAIT_LAST);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    id_d      = id_q;
    acc_d     = acc_q;
    pass_d    = pass_q;
    wcnt_d    = wcnt_q;
    last_id_d = last_id_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          a_d     = grant_id ? req1_a : req0_a;
          b_d     = grant_id ? req1_b : req0_b;
          id_d    = grant_id;
          acc_d   = 16'h0000;
          pass_d  = 2'd0;
          wcnt_d  = 3'd0;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        if (pass_end) begin
          acc_d  = acc_q + pp_shifted;
          wcnt_d = 3'd0;
          pass_d = pass_q + 2'd1;
          if (pass_q == 2'd3) begin
            state_d = ST_DONE;
          end
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          last_id_d = id_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      id_q      <= 1'b0;
      acc_q     <= 16'h0000;
      pass_q    <= 2'd0;
      wcnt_q    <= 3'd0;
      last_id_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      id_q      <= id_d;
      acc_q     <= acc_d;
      pass_q    <= pass_d;
      wcnt_q    <= wcnt_d;
      last_id_q <= last_id_d;
      busy_q    <= busy_d;
    end
  end

  // Result outputs are zero outside DONE so a stale accumulator never leaks out.
  assign res_valid = (state_q == ST_DONE);
  assign res_p     = res_valid ? acc_q : 16'h0000;
  assign res_id    = res_valid ? id_q : 1'b0;
  assign busy      = busy_q;

endmodule

// File: doc/mul8_seq_ctrl.md
# mul8_seq_ctrl

Sequencing controller that shares a single combinational 4x4 array multiplier between two requesters and produces full 8x8 → 16-bit products. Each product is built in four passes over the 4-bit multiplier, accumulating shifted partial products. The block sits between two operand sources and one shared 4x4 multiplier instance. It owns arbitration, operand slicing, accumulation and result handshaking.

## Interface

Parameters:
- WAIT_CYCLES, default 0: extra settle cycles per pass before `mul_p` is sampled. Range 0–7.

Ports:
- clk  in  1  Single clock, rising edge.
- rst  in  1  Asynchronous reset, active-high.
- req0_valid  in  1  Requester 0 has an operand pair.
- req0_a  in  8  Requester 0 multiplicand, unsigned.
- req0_b  in  8  Requester 0 multiplier, unsigned.
- req0_ready  out  1  Requester 0 pair accepted this cycle.
- req1_valid, req1_a, req1_b, req1_ready: same as requester 0, for requester 1.
- mul_a  out  4  Operand nibble driven to the shared 4x4 multiplier.
- mul_b  out  4  Operand nibble driven to the shared 4x4 multiplier.
- mul_p  in  8  Product returned by the shared 4x4 multiplier (combinational).
- res_valid  out  1  Result available.
- res_ready  in  1  Consumer accepts the result.
- res_p  out  16  Product a*b.
- res_id  out  1  Index of the requester that owns `res_p`.
- busy  out  1  High in any state other than IDLE.

## Operation

- FSM states: IDLE, PASS, DONE.
- IDLE:
  - `mul_a` = `mul_b` = 0.
  - Grant is decided combinationally:
    - If only one requester is valid, that requester is granted.
    - If both are valid, the requester that is not `last_id` is granted (round-robin).
  - `reqN_ready` = (state==IDLE) & grant==N. At most one ready is high at a time.
  - On `valid & ready`:
    - Latch the a, b and id of the granted requester.
    - Clear `acc`, `pass`=0 and `wcnt`=0.
    - Go to PASS.
- PASS:
  - Pass index 0..3 selects the operands and shift:
    - Pass 0: (a[3:0], b[3:0]), shift 0.
    - Pass 1: (a[7:4], b[3:0]), shift 4.
    - Pass 2: (a[3:0], b[7:4]), shift 4.
    - Pass 3: (a[7:4], b[7:4]), shift 8.
  - Each pass lasts WAIT_CYCLES+1 cycles.
  - On the last cycle of a pass: `acc` <= `acc` + (`mul_p` << shift), computed at 16-bit width with no overflow possible (max 0xFE01).
  - After pass 3 accumulates, go to DONE.
- DONE:
  - `res_valid`=1, `res_p`=`acc`, `res_id`=latched id.
  - All three hold stable until `res_ready`.
  - On `res_valid & res_ready`: `last_id` <= id, go to IDLE.
- Requester operands are sampled only at the accept edge. Later changes on `req*_a`/`req*_b` have no effect on the operation in flight.
- `req*_valid` may drop before acceptance without error. There is no request queue.
- `mul_p` is used only at pass-end sampling. Its value at other times is ignored.

## Timing

- Reset, asynchronous and effective immediately:
  - state=IDLE.
  - `acc`, `res_p`, `res_id`, `res_valid`, `busy`, `mul_a`, `mul_b`, `pass` and `wcnt` all 0.
  - `last_id`=1, so requester 0 wins the first tie.
  - `req*_ready` then follows the IDLE grant rule combinationally.
- Reset mid-PASS or mid-DONE: the operation is abandoned. No `res_valid` pulse follows.
- Latency: with the accept edge as E0, `res_valid` is first high after edge E0 + 4·(WAIT_CYCLES+1).
- Throughput: the next accept can occur no earlier than the cycle after the result handshake. With WAIT_CYCLES=0 and `res_ready` tied high, that is one product every 6 cycles.
- Simultaneous events:
  - A new `req*_valid` during PASS or DONE is ignored until IDLE.
  - `res_ready` high outside DONE has no effect.
  - `res_ready` high on the first DONE cycle completes the handshake in that cycle.
- `busy` is registered and equals (state != IDLE).

## Test plan

- Single operation: req0 a=0xFF, b=0xFF, WAIT_CYCLES=0.
  - Required: `mul_a`/`mul_b` sequence (F,F) four times.
  - Required: `res_p`=0xFE01 and `res_id`=0, with `res_valid` first high 4 cycles after accept.
- Nibble order: req1 a=0x3C, b=0xA5.
  - Required `mul_a`/`mul_b` sequence: (C,5), (3,5), (C,A), (3,A).
  - Required: `res_p`=0x26AC, `res_id`=1.
- Arbitration: req0 and req1 both held valid from reset, with `res_ready`=1.
  - Required grant order 0,1,0,1.
  - Required: `reqN_ready` never high for both requesters in the same cycle.
  - Required: accepts spaced exactly 6 cycles apart.
- Backpressure: `res_ready`=0 for 10 cycles in DONE.
  - Required: `res_valid`, `res_p` and `res_id` stable, `busy`=1, both readies low.
  - Required: after `res_ready`=1, IDLE is reached on the next edge.
- Reset in pass 2: assert `rst` mid-PASS.
  - Required: outputs return to reset values immediately and no `res_valid` is seen.
  - Required: the next request completes correctly.
- Random check: WAIT_CYCLES=2, 2000 random pairs on both ports with random `res_ready`.
  - Required: every result equals a*b and carries the correct id.
  - Required: latency from accept to `res_valid` = 12 cycles.
